id_operand_stage: RTL and testbench

Parametrised decode-side operand stage that sits between the instruction decoder and EX. It resolves source operands through N-deep register forwarding and detects load-use hazards. It interlocks the pipeline with a two-state FSM and registers the result into the ID/EX pipeline register with valid, hold and flush control. It also keeps saturating interlock performance counters.

---
 rtl/id_operand_stage.sv | 120 ++++++++++++
 tb/tb_id_operand_stage.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/id_operand_stage.sv
// id_operand_stage: operand resolution with forwarding, load-use interlock, ID/EX register and saturating interlock counters (forwarding enabled by ID_FWD_EN)
module id_operand_stage #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 5,
  parameter int FWD_PORTS = 2,
  parameter int CNT_W     = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        id_valid_i,
  input  logic                        reg1_re_i,
  input  logic                        reg2_re_i,
  input  logic [ADDR_W-1:0]           reg1_addr_i,
  input  logic [ADDR_W-1:0]           reg2_addr_i,
  input  logic [DATA_W-1:0]           reg1_data_i,
  input  logic [DATA_W-1:0]           reg2_data_i,
  input  logic [DATA_W-1:0]           imm_i,
  input  logic [ADDR_W-1:0]           waddr_i,
  input  logic                        we_i,
  input  logic [7:0]                  aluop_i,
  input  logic [2:0]                  alusel_i,
  input  logic [FWD_PORTS-1:0]        fwd_we_i,
  input  logic [FWD_PORTS*ADDR_W-1:0] fwd_waddr_i,
  input  logic [FWD_PORTS*DATA_W-1:0] fwd_wdata_i,
  input  logic [FWD_PORTS-1:0]        fwd_pend_i,
  input  logic                        stall_i,
  input  logic                        flush_i,
  output logic                        ex_valid_o,
  output logic [DATA_W-1:0]           ex_reg1_o,
  output logic [DATA_W-1:0]           ex_reg2_o,
  output logic [ADDR_W-1:0]           ex_waddr_o,
  output logic                        ex_we_o,
  output logic [7:0]                  ex_aluop_o,
  output logic [2:0]                  ex_alusel_o,
  output logic                        stallreq_o,
  output logic [CNT_W-1:0]            ilk_evt_o,
  output logic [CNT_W-1:0]            ilk_cyc_o
);
  typedef enum logic {RUN, ILK} state_t;
  state_t state, state_nx;
  logic [FWD_PORTS-1:0] m1, m2;
  logic [DATA_W-1:0] rf1, rf2, op1, op2;
  logic hazard, bubble, evt_inc;
  // per-source address match for both operands; register 0 never matches
  always_comb begin
    m1 = '0;
    m2 = '0;
    for (int k = 0; k < FWD_PORTS; k++) begin
      m1[k] = reg1_re_i && fwd_we_i[k] && reg1_addr_i != '0 && fwd_waddr_i[k*ADDR_W +: ADDR_W] == reg1_addr_i;
      m2[k] = reg2_re_i && fwd_we_i[k] && reg2_addr_i != '0 && fwd_waddr_i[k*ADDR_W +: ADDR_W] == reg2_addr_i;
    end
  end
  assign rf1 = reg1_addr_i == '0 ? '0 : reg1_data_i;
  assign rf2 = reg2_addr_i == '0 ? '0 : reg2_data_i;
`ifdef ID_FWD_EN
  logic [FWD_PORTS-1:0] w1, w2;
  logic [DATA_W-1:0] f1, f2;
  assign w1 = m1 & (~m1 + FWD_PORTS'(1));
  assign w2 = m2 & (~m2 + FWD_PORTS'(1));
  // youngest matching source drives the forwarded value
  always_comb begin
    f1 = '0;
    f2 = '0;
    for (int k = 0; k < FWD_PORTS; k++) begin
      f1 = f1 | ({DATA_W{w1[k]}} & fwd_wdata_i[k*DATA_W +: DATA_W]);
      f2 = f2 | ({DATA_W{w2[k]}} & fwd_wdata_i[k*DATA_W +: DATA_W]);
    end
  end
  assign hazard = id_valid_i && |((w1 | w2) & fwd_pend_i);
  assign op1 = !reg1_re_i ? imm_i : |m1 ? f1 : rf1;
  assign op2 = !reg2_re_i ? imm_i : |m2 ? f2 : rf2;
`else
  logic unused_fwd;
  assign unused_fwd = ^{fwd_wdata_i, fwd_pend_i};
  assign hazard = id_valid_i && |(m1 | m2);
  assign op1 = reg1_re_i ? rf1 : imm_i;
  assign op2 = reg2_re_i ? rf2 : imm_i;
`endif
  assign stallreq_o = rst && hazard;
  assign bubble = hazard && !flush_i && !stall_i;
  // ID/EX register: flush beats hold, hold beats bubble
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      ex_valid_o  <= 1'b0;
      ex_we_o     <= 1'b0;
      ex_reg1_o   <= '0;
      ex_reg2_o   <= '0;
      ex_waddr_o  <= '0;
      ex_aluop_o  <= '0;
      ex_alusel_o <= '0;
    end else if (flush_i) begin
      ex_valid_o <= 1'b0;
      ex_we_o    <= 1'b0;
    end else if (!stall_i) begin
      ex_valid_o  <= id_valid_i && !hazard;
      ex_we_o     <= we_i && id_valid_i && !hazard;
      ex_reg1_o   <= hazard ? '0 : op1;
      ex_reg2_o   <= hazard ? '0 : op2;
      ex_waddr_o  <= hazard ? '0 : waddr_i;
      ex_aluop_o  <= hazard ? '0 : aluop_i;
      ex_alusel_o <= hazard ? '0 : alusel_i;
    end
  // interlock state register
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= RUN;
    else state <= state_nx;
  // stay interlocked exactly while bubbles keep being inserted
  always_comb state_nx = bubble ? ILK : RUN;
  // an interlock event is the first bubble after a run of normal cycles
  always_comb evt_inc = bubble && state == RUN;
  // saturating performance counters
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      ilk_evt_o <= '0;
      ilk_cyc_o <= '0;
    end else begin
      if (evt_inc && !(&ilk_evt_o)) ilk_evt_o <= ilk_evt_o + CNT_W'(1);
      if (bubble && !(&ilk_cyc_o)) ilk_cyc_o <= ilk_cyc_o + CNT_W'(1);
    end
endmodule

// File: tb/tb_id_operand_stage.sv
// tb_id_operand_stage: directed vectors with scoreboard checking of id_operand_stage (expectations follow ID_FWD_EN)
module tb_id_operand_stage;
`ifdef ID_FWD_EN
  localparam bit FW = 1'b1;
`else
  localparam bit FW = 1'b0;
`endif
  logic clk = 0, rst = 1;
  logic v, re1, re2, we, st, fl;
  logic [4:0] a1, a2, wa;
  logic [31:0] d1, d2, imm;
  logic [7:0] op = 8'h10;
  logic [2:0] sel = 3'd0;
  logic [1:0] fwe, pend;
  logic [9:0] fwa;
  logic [63:0] fwd;
  logic ex_valid, ex_we, stallreq;
  logic [31:0] ex_r1, ex_r2;
  logic [4:0] ex_wa;
  logic [7:0] ex_op;
  logic [2:0] ex_sel;
  logic [15:0] evt, cyc;
  logic s_valid, s_we, s_stall;
  logic [31:0] s_r1, s_r2;
  logic [4:0] s_wa;
  logic [7:0] s_op;
  logic [2:0] s_sel;
  logic [3:0] evt4, cyc4;
  always #5 clk = ~clk;
  id_operand_stage dut (
    .clk(clk), .rst(rst), .id_valid_i(v), .reg1_re_i(re1), .reg2_re_i(re2),
    .reg1_addr_i(a1), .reg2_addr_i(a2), .reg1_data_i(d1), .reg2_data_i(d2), .imm_i(imm),
    .waddr_i(wa), .we_i(we), .aluop_i(op), .alusel_i(sel), .fwd_we_i(fwe), .fwd_waddr_i(fwa),
    .fwd_wdata_i(fwd), .fwd_pend_i(pend), .stall_i(st), .flush_i(fl),
    .ex_valid_o(ex_valid), .ex_reg1_o(ex_r1), .ex_reg2_o(ex_r2), .ex_waddr_o(ex_wa),
    .ex_we_o(ex_we), .ex_aluop_o(ex_op), .ex_alusel_o(ex_sel), .stallreq_o(stallreq),
    .ilk_evt_o(evt), .ilk_cyc_o(cyc));
  id_operand_stage #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .id_valid_i(v), .reg1_re_i(re1), .reg2_re_i(re2),
    .reg1_addr_i(a1), .reg2_addr_i(a2), .reg1_data_i(d1), .reg2_data_i(d2), .imm_i(imm),
    .waddr_i(wa), .we_i(we), .aluop_i(op), .alusel_i(sel), .fwd_we_i(fwe), .fwd_waddr_i(fwa),
    .fwd_wdata_i(fwd), .fwd_pend_i(pend), .stall_i(st), .flush_i(fl),
    .ex_valid_o(s_valid), .ex_reg1_o(s_r1), .ex_reg2_o(s_r2), .ex_waddr_o(s_wa),
    .ex_we_o(s_we), .ex_aluop_o(s_op), .ex_alusel_o(s_sel), .stallreq_o(s_stall),
    .ilk_evt_o(evt4), .ilk_cyc_o(cyc4));
  typedef struct {
    logic v, we, known;
    logic [31:0] r1, r2;
    logic [4:0] wa;
    logic [7:0] op;
    logic [2:0] sel;
    logic [15:0] evt, cyc;
    logic [3:0] evt4, cyc4;
  } exp_t;
  exp_t cur, q[$];
  int total = 0, bad = 0;
  logic ilk = 0;
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", n, a, e);
    end
  endtask
  task automatic clr();
    v = 1; re1 = 1; re2 = 1; we = 1; st = 0; fl = 0;
    a1 = 5'd1; a2 = 5'd2; d1 = 0; d2 = 0; imm = 0;
    fwe = 0; pend = 0; fwa = 0; fwd = 0;
    wa = wa + 5'd1; op = op + 8'd3; sel = sel + 3'd1;
  endtask
  task automatic rnd();
    {v, re1, re2, we, st, fl} = 6'($urandom);
    a1 = 5'($urandom); a2 = 5'($urandom); wa = 5'($urandom);
    d1 = $urandom; d2 = $urandom; imm = $urandom;
    op = 8'($urandom); sel = 3'($urandom);
    fwe = 2'($urandom); pend = 2'($urandom); fwa = 10'($urandom); fwd = {$urandom, $urandom};
  endtask
  task automatic step(input logic hz, input logic [31:0] e1, input logic [31:0] e2);
    logic bub;
    #1 chk("stallreq", stallreq, hz);
    bub = hz && !st && !fl;
    if (fl) begin
      cur.v = 0; cur.we = 0; cur.known = 0;
    end else if (!st) begin
      cur.v = v && !hz; cur.we = we && v && !hz; cur.known = 1;
      cur.r1 = hz ? 0 : e1; cur.r2 = hz ? 0 : e2;
      cur.wa = hz ? 0 : wa; cur.op = hz ? 0 : op; cur.sel = hz ? 0 : sel;
    end
    if (bub) begin
      if (!ilk && cur.evt != 16'hFFFF) cur.evt = cur.evt + 1;
      if (!ilk && cur.evt4 != 4'hF) cur.evt4 = cur.evt4 + 1;
      if (cur.cyc != 16'hFFFF) cur.cyc = cur.cyc + 1;
      if (cur.cyc4 != 4'hF) cur.cyc4 = cur.cyc4 + 1;
    end
    ilk = bub;
    q.push_back(cur);
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic chk_reset(input string n);
    chk({n, "_ctl"}, {ex_valid, ex_we, ex_wa, ex_op, ex_sel}, 0);
    chk({n, "_ops"}, {ex_r1, ex_r2}, 0);
    chk({n, "_cnt"}, {evt, cyc, evt4, cyc4}, 0);
    chk({n, "_stallreq"}, stallreq, 0);
  endtask
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("ex_valid", ex_valid, e.v);
      chk("ex_we", ex_we, e.we);
      if (e.known) begin
        chk("ex_reg1", ex_r1, e.r1);
        chk("ex_reg2", ex_r2, e.r2);
        chk("ex_ctl", {ex_wa, ex_op, ex_sel}, {e.wa, e.op, e.sel});
      end
      chk("ilk_evt", evt, e.evt);
      chk("ilk_cyc", cyc, e.cyc);
      chk("ilk_evt4", evt4, e.evt4);
      chk("ilk_cyc4", cyc4, e.cyc4);
    end
  end
  initial begin
    cur = '{default: '0};
    clr();
    #2 rst = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      rnd();
      #1 chk_reset("reset");
    end
    @(negedge clk);
    clr();
    rst = 1;
    #1;
    clr(); d1 = 32'h11; re2 = 0; imm = 32'h22;
    step(0, 32'h11, 32'h22);
    clr(); fwe = 2'b01; fwa = {5'd0, 5'd3}; fwd = {32'h0, 32'h1234}; a1 = 3; d1 = 32'hDEAD; a2 = 4; d2 = 32'h44;
    step(!FW, 32'h1234, 32'h44);
    clr(); fwe = 2'b11; fwa = {5'd5, 5'd5}; fwd = {32'hBBBB, 32'hAAAA}; re1 = 0; imm = 7; a2 = 5; d2 = 32'hCCCC;
    step(!FW, 32'h7, 32'hAAAA);
    clr(); fwe = 2'b11; fwa = 0; fwd = {32'hBBBB, 32'hAAAA}; a1 = 0; a2 = 0; d1 = 32'hFFFF; d2 = 32'hEEEE;
    step(0, 32'h0, 32'h0);
    clr(); fwe = 2'b11; fwa = {5'd6, 5'd6}; fwd = {32'h77, 32'h66}; pend = 2'b10; a1 = 6; d1 = 3; a2 = 1; d2 = 8;
    step(!FW, FW ? 32'h66 : 32'h3, 32'h8);
    clr(); fwe = 2'b01; fwa = {5'd0, 5'd7}; fwd = {32'h0, 32'hBAD}; pend = 2'b01; a1 = 7; d1 = 1; a2 = 1; d2 = 2;
    step(1, 32'h0, 32'h0);
    clr(); fwe = 2'b10; fwa = {5'd7, 5'd0}; fwd = {32'h55, 32'h0}; a1 = 7; d1 = 1; a2 = 1; d2 = 2;
    step(!FW, 32'h55, 32'h2);
    clr(); a1 = 7; d1 = 32'h55; a2 = 1; d2 = 2; we = 0;
    step(0, 32'h55, 32'h2);
    clr(); fwe = 2'b01; fwa = {5'd0, 5'd2}; pend = 2'b01; a1 = 2; st = 1;
    step(1, 32'h0, 32'h0);
    clr(); st = 1; fl = 1;
    step(0, 32'h0, 32'h0);
    clr(); v = 0; fwe = 2'b01; fwa = {5'd0, 5'd2}; fwd = {32'h0, 32'h5}; pend = 2'b01; a1 = 2; d1 = 9; a2 = 1; d2 = 3;
    step(0, FW ? 32'h5 : 32'h9, 32'h3);
    for (int i = 0; i < 20; i++) begin
      clr(); fwe = 2'b01; fwa = {5'd0, 5'd9}; pend = 2'b01; a1 = 9;
      step(1, 32'h0, 32'h0);
    end
    rst = 0;
    rnd();
    #1 chk_reset("midreset");
    @(negedge clk);
    rst = 1;
    cur = '{default: '0};
    ilk = 0;
    clr(); fwe = 2'b01; fwa = {5'd0, 5'd9}; pend = 2'b01; a1 = 9;
    step(1, 32'h0, 32'h0);
    clr(); d1 = 32'h31; d2 = 32'h32;
    step(0, 32'h31, 32'h32);
    repeat (2) @(negedge clk);
    chk("queue_drained", 64'(q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
